// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with slave split parking and a per-grant hold limit.
// Grants are decoded straight from the state register, so reset removes them asynchronously.
//
//   state  | meaning
//   IDLE   | no grant; arbitrate among eligible requests
//   OWN_M1 | master 1 owns the bus
//   OWN_M2 | master 2 owns the bus
module bus_arbiter #(
  parameter int HOLD_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_request,
  input  logic m2_request,
  input  logic tx_done,
  input  logic split_en,
  output logic m1_grant,
  output logic m2_grant,
  output logic bus_sel,
  output logic split_pending,
  output logic timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OWN_M1 = 2'd1;
  localparam logic [1:0] OWN_M2 = 2'd2;

  localparam logic [1:0] SPLIT_NONE = 2'd0;
  localparam logic [1:0] SPLIT_M1   = 2'd1;
  localparam logic [1:0] SPLIT_M2   = 2'd2;

  // Last OWN cycle index; the grant is revoked after HOLD_MAX cycles of ownership.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] hold_q, hold_d;
  logic       bus_sel_q, bus_sel_d;
  logic       timeout_q, timeout_d;
  logic       split_en_q;

  logic       split_rise;
  logic       resumed;
  logic       m1_elig;
  logic       m2_elig;
  logic       own_req;
  logic [1:0] own_id;

  assign split_rise = split_en & ~split_en_q;
  assign resumed    = (owner_q != SPLIT_NONE) & ~split_en;
  assign m1_elig    = m1_request & ~((owner_q == SPLIT_M1) & split_en);
  assign m2_elig    = m2_request & ~((owner_q == SPLIT_M2) & split_en);
  assign own_req    = (state_q == OWN_M2) ? m2_request : m1_request;
  assign own_id     = (state_q == OWN_M2) ? SPLIT_M2 : SPLIT_M1;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    bus_sel_d = bus_sel_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (resumed && (owner_q == SPLIT_M1) && m1_request) begin
          state_d   = OWN_M1;
          bus_sel_d = 1'b0;
          owner_d   = SPLIT_NONE;
        end else if (resumed && (owner_q == SPLIT_M2) && m2_request) begin
          state_d   = OWN_M2;
          bus_sel_d = 1'b1;
          owner_d   = SPLIT_NONE;
        end else begin
          // A resumed master that no longer wants the bus simply forfeits its slot.
          if (resumed) owner_d = SPLIT_NONE;
          if (m1_elig) begin
            state_d   = OWN_M1;
            bus_sel_d = 1'b0;
          end else if (m2_elig) begin
            state_d   = OWN_M2;
            bus_sel_d = 1'b1;
          end
        end
      end
      OWN_M1, OWN_M2: begin
        hold_d = hold_q + 8'd1;
        if (tx_done || !own_req) begin
          state_d = IDLE;
        end else if (split_rise && (owner_q == SPLIT_NONE)) begin
          owner_d = own_id;
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= SPLIT_NONE;
      hold_q     <= '0;
      bus_sel_q  <= 1'b0;
      timeout_q  <= 1'b0;
      split_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      bus_sel_q  <= bus_sel_d;
      timeout_q  <= timeout_d;
      split_en_q <= split_en;
    end
  end

  assign m1_grant      = (state_q == OWN_M1);
  assign m2_grant      = (state_q == OWN_M2);
  assign bus_sel       = bus_sel_q;
  assign split_pending = (owner_q != SPLIT_NONE);
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle-by-cycle vector table plus
// hand-written hold-limit and mid-grant reset sequences.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic m1_request, m2_request, tx_done, split_en;
  logic m1_grant, m2_grant, bus_sel, split_pending, timeout;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .m1_request   (m1_request),
    .m2_request   (m2_request),
    .tx_done      (tx_done),
    .split_en     (split_en),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .bus_sel      (bus_sel),
    .split_pending(split_pending),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Expected-output packing: {m1_grant, m2_grant, bus_sel, split_pending, timeout}
  typedef struct {
    logic       m1;
    logic       m2;
    logic       tx;
    logic       sp;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m1, input logic m2, input logic tx, input logic sp,
                     input logic [4:0] e);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.tx = tx; v.sp = sp; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic m1, input logic m2, input logic tx, input logic sp);
    m1_request = m1; m2_request = m2; tx_done = tx; split_en = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {m1_grant, m2_grant, bus_sel, split_pending, timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got g1/g2/sel/spend/tmo=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    // simultaneous requests: m1 first, one idle cycle, then m2
    add(1,1,0,0, 5'b10000);
    add(1,1,1,0, 5'b00000);
    add(0,1,0,0, 5'b01100);
    add(0,1,1,0, 5'b00100);
    add(0,0,0,0, 5'b00100);
    // split of m1, m2 served, m1 resumes ahead of m2
    add(1,0,0,0, 5'b10000);
    add(1,0,0,1, 5'b00010);
    add(1,1,0,1, 5'b01110);
    add(1,1,0,0, 5'b01110);
    add(1,1,1,0, 5'b00110);
    add(1,1,0,0, 5'b10000);
    add(1,0,1,0, 5'b00000);
    add(0,0,0,0, 5'b00000);
    // tx_done beats a same-cycle split edge
    add(0,1,0,0, 5'b01100);
    add(0,1,1,1, 5'b00100);
    add(0,0,0,1, 5'b00100);
    add(0,0,0,0, 5'b00100);
    // split master ineligible while parked, then forfeits by dropping request
    add(0,1,0,0, 5'b01100);
    add(0,1,0,1, 5'b00110);
    add(0,1,0,1, 5'b00110);
    add(0,0,0,1, 5'b00110);
    add(0,0,0,0, 5'b00100);
    add(0,1,0,0, 5'b01100);
    add(0,0,0,0, 5'b00100);
    // second split edge while one is parked is ignored
    add(1,0,0,0, 5'b10000);
    add(1,0,0,1, 5'b00010);
    add(1,1,0,1, 5'b01110);
    add(1,1,0,0, 5'b01110);
    add(1,1,0,1, 5'b01110);
    add(1,1,1,1, 5'b00110);
    add(1,0,0,1, 5'b00110);
    add(1,0,0,0, 5'b10000);
    add(0,0,0,0, 5'b00000);

    reset = 1'b0;
    drive(0,0,0,0);
    #12;
    check("reset_state", 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    #4;

    foreach (vecs[i]) begin
      drive(vecs[i].m1, vecs[i].m2, vecs[i].tx, vecs[i].sp);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // hold limit: 4 granted cycles, then revoke with a one-cycle timeout pulse
    drive(0,1,0,0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hold_cycle%0d", c + 1), 5'b01100);
    end
    tick();
    check("timeout_revoke", 5'b00101);
    tick();
    check("timeout_regrant", 5'b01100);
    drive(0,0,0,0);
    tick();
    check("timeout_release", 5'b00100);

    // reset in OWN_M1 while m2 is parked
    drive(0,1,0,0);
    tick();
    check("rst_pre_m2", 5'b01100);
    drive(0,1,0,1);
    tick();
    check("rst_pre_split", 5'b00110);
    drive(1,0,0,1);
    tick();
    check("rst_pre_m1", 5'b10010);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", 5'b00000);
    tick();
    check("rst_held", 5'b00000);
    drive(0,1,0,0);
    reset = 1'b1;
    tick();
    check("rst_first_grant", 5'b01100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 255, meaning the maximum cycles one master may hold a grant without completing.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m1_request, m2_request  input  1 each  bus requests from master 1 and master 2, held until grant or withdrawal.
REQ-005 SHALL have port tx_done  input  1  one-cycle pulse from the owning master when its transaction completes.
REQ-006 SHALL have port split_en  input  1  slave split level; high means the current transaction is suspended by the slave.
REQ-007 SHALL have ports m1_grant, m2_grant  output  1 each  registered bus grants.
REQ-008 SHALL have port bus_sel  output  1  master mux select (0 = master 1, 1 = master 2), holding its last value when no grant is active.
REQ-009 SHALL have port split_pending  output  1  high while a split master is parked.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 SHALL implement states IDLE, OWN_M1 and OWN_M2, plus a split_owner register with values NONE, M1 or M2.
REQ-012 SHALL drive m1_grant high exactly in OWN_M1 and m2_grant high exactly in OWN_M2; the two grants are never high together.
REQ-013 SHALL, from IDLE, move to OWN_x on the next edge after an eligible request, giving first grant latency of 1 cycle.
REQ-014 SHALL apply this IDLE priority: resumed split master first, then master 1, then master 2.
REQ-015 SHALL treat master x as ineligible while split_owner==x and split_en is high.
REQ-016 SHALL, in OWN_x, return to IDLE on the next edge when tx_done is high or m_x_request drops; IDLE lasts at least 1 cycle before any new grant.
REQ-017 SHALL, on a split_en rising edge in OWN_x with split_owner==NONE, record split_owner=x and go to IDLE on the next edge.
REQ-018 SHALL ignore split_en edges while split_owner!=NONE, recording no second split.
REQ-019 SHALL, when tx_done and a split_en rising edge occur in the same cycle, let tx_done win: go to IDLE and record no split.
REQ-020 SHALL treat a split as resumed once split_en is low with split_owner==x; in IDLE, grant x if m_x_request is high, otherwise clear split_owner to NONE.
REQ-021 SHALL not preempt the current owner when a split resumes; the resumed master waits for IDLE.
REQ-022 SHALL count cycles in OWN_x with an 8-bit hold counter that clears on entry; reaching HOLD_MAX with no tx_done forces IDLE on the next edge and pulses timeout high for 1 cycle.
REQ-023 SHALL never time out a parked split master; the hold counter runs only in OWN_x.
REQ-024 SHALL drive split_pending = (split_owner != NONE).
REQ-025 SHALL update bus_sel on the same edge as the grant it accompanies.

Reset
REQ-026 SHALL, with reset low, force state IDLE, split_owner NONE, hold counter 0, m1_grant 0, m2_grant 0, bus_sel 0, split_pending 0, timeout 0, and the registered split_en history to 0.
REQ-027 SHALL, on reset asserted mid-grant, drop grants immediately (asynchronously) and issue no timeout or split record.
REQ-028 SHALL arbitrate normally on the first rising edge after reset deasserts.

Verification
REQ-029 Simultaneous m1_request and m2_request from IDLE -> m1_grant=1 and bus_sel=0 one cycle later; after tx_done, 1 IDLE cycle, then m2_grant=1 and bus_sel=1.
REQ-030 OWN_M1 with split_en rising -> m1_grant=0 next cycle, split_pending=1, m2 granted; split_en falls during the m2 grant -> m1 waits for m2 tx_done, then m1_grant=1 ahead of a new m2 request and split_pending=0 after m1 is granted.
REQ-031 HOLD_MAX=4, m2 holds the grant with no tx_done -> m2_grant falls after cycle 4 and timeout pulses for 1 cycle.
REQ-032 tx_done and split_en rising in the same cycle while in OWN_M2 -> IDLE and split_pending=0.
REQ-033 Reset pulsed low during OWN_M1 with split_pending=1 -> all outputs 0 immediately; after release, m2_request alone -> m2_grant=1 one cycle later.
REQ-034 Split master drops its request before resuming -> split_owner cleared in IDLE and no grant issued to it.
